// File: rtl/dac_pkg.sv
// Shared constants, state encoding and code conversion for the AD9767 I/Q scheduler.
package dac_pkg;

    localparam int unsigned DAC_WIDTH = 14;
    localparam logic [DAC_WIDTH-1:0] MIDSCALE = 14'h2000;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        A_SETUP,
        A_WRT,
        B_SETUP,
        B_WRT
    } state_e;

    // Two's complement to offset binary is a flip of the MSB (+8192 mod 2^14).
    function automatic logic [DAC_WIDTH-1:0] to_offset_binary(input logic [DAC_WIDTH-1:0] w,
                                                              input bit is_signed);
        return is_signed ? {~w[DAC_WIDTH-1], w[DAC_WIDTH-2:0]} : w;
    endfunction

endpackage

// File: rtl/dac_iq_scheduler_if.sv
// Dual sample-stream valid/ready bundle feeding the I/Q scheduler.
interface dac_iq_scheduler_if #(
    parameter int unsigned INPUT_WIDTH = 14
);
    logic [INPUT_WIDTH-1:0] a_data;
    logic                   a_valid;
    logic                   a_ready;
    logic [INPUT_WIDTH-1:0] b_data;
    logic                   b_valid;
    logic                   b_ready;

    modport master (
        output a_data, a_valid, b_data, b_valid,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_data, a_valid, b_data, b_valid,
        output a_ready, b_ready
    );
endinterface

// File: rtl/dac_sample_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module dac_sample_fifo #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Status flags, guarded push/pop and pointer advance.
    always_comb begin
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_o  = (wr_ptr_q == rd_ptr_q);
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        rdata_o  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers; reset flushes the queue.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end
endmodule

// File: rtl/dac_iq_scheduler.sv
// Interleaves channel A (I) and B (Q) samples onto the single AD9767 data port.
module dac_iq_scheduler
    import dac_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH   = 14,
    parameter string       INPUT_STYLE   = "signed",
    parameter string       ALIGNED_STYLE = "LSB",
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic                      enable,
    dac_iq_scheduler_if.slave         s_if,
    output logic [DAC_WIDTH-1:0]      DA_out,
    output logic                      DA_sel,
    output logic                      DA_wrt,
    output logic                      busy,
    output logic                      frame_tick,
    output logic [15:0]               underrun_cnt
);
    localparam bit IsSigned = (INPUT_STYLE == "signed");
    localparam bit AlignMsb = (ALIGNED_STYLE == "MSB");
    localparam logic [DAC_WIDTH-1:0] IDLE_CODE = IsSigned ? MIDSCALE : 14'h0000;

    logic [INPUT_WIDTH-1:0] a_rdata, b_rdata;
    logic                   a_full, a_empty, b_full, b_empty;
    logic                   pop_a, pop_b, load_a, load_b;
    logic [DAC_WIDTH-1:0]   a_align, b_align, a_conv, b_conv;

    state_e               state_q, state_d;
    logic [DAC_WIDTH-1:0] da_out_q, da_out_d;
    logic [DAC_WIDTH-1:0] last_a_q, last_a_d;
    logic [DAC_WIDTH-1:0] last_b_q, last_b_d;
    logic                 da_sel_q, da_sel_d;
    logic                 da_wrt_q, da_wrt_d;
    logic                 frame_tick_q, frame_tick_d;
    logic [15:0]          underrun_q, underrun_d;

    dac_sample_fifo #(.WIDTH(INPUT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk_in  (clk_in),
        .rst     (rst),
        .push_i  (s_if.a_valid),
        .wdata_i (s_if.a_data),
        .pop_i   (pop_a),
        .rdata_o (a_rdata),
        .full_o  (a_full),
        .empty_o (a_empty)
    );

    dac_sample_fifo #(.WIDTH(INPUT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk_in  (clk_in),
        .rst     (rst),
        .push_i  (s_if.b_valid),
        .wdata_i (s_if.b_data),
        .pop_i   (pop_b),
        .rdata_o (b_rdata),
        .full_o  (b_full),
        .empty_o (b_empty)
    );

    assign s_if.a_ready = !a_full;
    assign s_if.b_ready = !b_full;

    // Bring FIFO head words onto the 14-bit DAC grid.
    if (AlignMsb && (INPUT_WIDTH < DAC_WIDTH)) begin : g_msb
        localparam int unsigned Pad = DAC_WIDTH - INPUT_WIDTH;
        assign a_align = {a_rdata, {Pad{1'b0}}};
        assign b_align = {b_rdata, {Pad{1'b0}}};
    end else if (INPUT_WIDTH < DAC_WIDTH) begin : g_lsb
        localparam int unsigned Pad = DAC_WIDTH - INPUT_WIDTH;
        assign a_align = {{Pad{IsSigned & a_rdata[INPUT_WIDTH-1]}}, a_rdata};
        assign b_align = {{Pad{IsSigned & b_rdata[INPUT_WIDTH-1]}}, b_rdata};
    end else begin : g_top
        assign a_align = a_rdata[INPUT_WIDTH-1 -: DAC_WIDTH];
        assign b_align = b_rdata[INPUT_WIDTH-1 -: DAC_WIDTH];
    end

    assign a_conv = to_offset_binary(a_align, IsSigned);
    assign b_conv = to_offset_binary(b_align, IsSigned);

    // Next state and next registered outputs; outputs are set on the edge entering a state.
    always_comb begin
        state_d      = state_q;
        da_out_d     = da_out_q;
        da_sel_d     = da_sel_q;
        da_wrt_d     = 1'b0;
        frame_tick_d = 1'b0;
        last_a_d     = last_a_q;
        last_b_d     = last_b_q;
        underrun_d   = underrun_q;
        load_a       = 1'b0;
        load_b       = 1'b0;
        pop_a        = 1'b0;
        pop_b        = 1'b0;

        unique case (state_q)
            IDLE: begin
                da_out_d = IDLE_CODE;
                if (enable) state_d = PRIME;
            end
            PRIME: begin
                if (!enable) begin
                    state_d  = IDLE;
                    da_out_d = IDLE_CODE;
                end else if (!a_empty && !b_empty) begin
                    state_d = A_SETUP;
                    load_a  = 1'b1;
                end
            end
            A_SETUP: begin
                state_d  = A_WRT;
                da_wrt_d = 1'b1;
            end
            A_WRT: begin
                state_d = B_SETUP;
                load_b  = 1'b1;
            end
            B_SETUP: begin
                state_d      = B_WRT;
                da_wrt_d     = 1'b1;
                frame_tick_d = 1'b1;
            end
            B_WRT: begin
                // A started frame always finishes here, so enable is only looked at now.
                if (enable) begin
                    state_d = A_SETUP;
                    load_a  = 1'b1;
                end else begin
                    state_d  = IDLE;
                    da_out_d = IDLE_CODE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_a) begin
            da_sel_d = 1'b1;
            if (!a_empty) begin
                pop_a    = 1'b1;
                da_out_d = a_conv;
                last_a_d = a_conv;
            end else begin
                da_out_d   = last_a_q;
                underrun_d = (underrun_q == 16'hFFFF) ? underrun_q : underrun_q + 16'd1;
            end
        end

        if (load_b) begin
            da_sel_d = 1'b0;
            if (!b_empty) begin
                pop_b    = 1'b1;
                da_out_d = b_conv;
                last_b_d = b_conv;
            end else begin
                da_out_d   = last_b_q;
                underrun_d = (underrun_q == 16'hFFFF) ? underrun_q : underrun_q + 16'd1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= IDLE;
            da_out_q     <= IDLE_CODE;
            da_sel_q     <= 1'b1;
            da_wrt_q     <= 1'b0;
            frame_tick_q <= 1'b0;
            underrun_q   <= 16'd0;
            last_a_q     <= IDLE_CODE;
            last_b_q     <= IDLE_CODE;
        end else begin
            state_q      <= state_d;
            da_out_q     <= da_out_d;
            da_sel_q     <= da_sel_d;
            da_wrt_q     <= da_wrt_d;
            frame_tick_q <= frame_tick_d;
            underrun_q   <= underrun_d;
            last_a_q     <= last_a_d;
            last_b_q     <= last_b_d;
        end
    end

    assign DA_out       = da_out_q;
    assign DA_sel       = da_sel_q;
    assign DA_wrt       = da_wrt_q;
    assign frame_tick   = frame_tick_q;
    assign underrun_cnt = underrun_q;
    assign busy         = (state_q != IDLE);
endmodule
